// File: rtl/rom_wr_responder_pkg.sv
// rom_dl_pkg: shared types for the ROM-download responder.
//   ROM_AW / ROM_DW  default word-address and data widths
//   fifo_entry_t     one captured write {addr, data}
//   drain_state_t    drain FSM states
//   mask_of()        smallest (2^n - 1) covering an address, n in 0..ROM_AW
package rom_dl_pkg;

  localparam int unsigned ROM_AW = 21;
  localparam int unsigned ROM_DW = 16;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [ROM_DW-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    WRITE
  } drain_state_t;

  // Grow an all-ones mask one bit at a time until it covers addr.
  function automatic logic [ROM_AW-1:0] mask_of(input logic [ROM_AW-1:0] addr);
    logic [ROM_AW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < ROM_AW; i++) begin
      if (m < addr) m = {m[ROM_AW-2:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/rom_wr_responder_if.sv
// rom_wr_responder_if: ROM-download toggle handshake.
//   rom_wr_req  requester -> responder, toggles once per word
//   rom_wr_ack  responder -> requester, toggles when a word is accepted
//   rom_addr    word address, held from req toggle to ack toggle
//   rom_data    write data, held over the same window
// master = requester side, slave = responder side.
interface rom_wr_responder_if #(
  parameter int unsigned AW = rom_dl_pkg::ROM_AW,
  parameter int unsigned DW = rom_dl_pkg::ROM_DW
);

  logic          rom_wr_req;
  logic          rom_wr_ack;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  modport master (
    output rom_wr_req,
    output rom_addr,
    output rom_data,
    input  rom_wr_ack
  );

  modport slave (
    input  rom_wr_req,
    input  rom_addr,
    input  rom_data,
    output rom_wr_ack
  );

endinterface

// File: rtl/rom_wr_responder_fifo2.sv
// rom_wr_fifo2: 2-entry FIFO of captured ROM writes.
//   clk_sys, RESET  clock, synchronous active-high reset
//   push, din       write din when push (caller guarantees count < 2)
//   pop             drop the head entry (caller guarantees count > 0)
//   head            current head entry
//   count           number of stored entries, 0..2
// Simultaneous push and pop leave count unchanged and advance both pointers.
module rom_wr_fifo2
  import rom_dl_pkg::*;
(
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t head,
  output logic [1:0]  count
);

  fifo_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rom_wr_responder.sv
// rom_wr_responder: responder end of the ROM-download toggle handshake.
// Captures each requested word into a 2-entry FIFO, acknowledges by toggling
// rom_wr_ack, drains words to the SDRAM write port (level req / pulse ack),
// and publishes a mirror mask once a download has finished and drained.
//   clk_sys, RESET  clock, synchronous active-high reset
//   rom             toggle handshake (slave modport)
//   downloading     high while a download is in progress
//   mem_req/mem_ack SDRAM write request (level) / commit (one-cycle pulse)
//   mem_addr        rom_addr + MEM_BASE
//   mem_wdata       write data
//   mem_be          byte enables, always 2'b11
//   busy            FIFO non-empty or write outstanding
//   rom_mask        smallest 2^n-1 covering highest address written
//   mask_valid      rom_mask valid; set after download end and drain
// Build option: ROM_REQ_SYNC_EN adds a 2-flop synchronizer on rom_wr_req for
// requesters on a foreign clock (ack latency 4 instead of 2).
module rom_wr_responder
  import rom_dl_pkg::*;
#(
  parameter int unsigned AW       = ROM_AW,
  parameter int unsigned DW       = ROM_DW,
  parameter int unsigned MEM_BASE = 0
) (
  input  logic                clk_sys,
  input  logic                RESET,
  rom_wr_responder_if.slave   rom,
  input  logic                downloading,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [AW:0]         mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [1:0]          mem_be,
  output logic                busy,
  output logic [AW-1:0]       rom_mask,
  output logic                mask_valid
);

  localparam logic [AW:0] BASE = (AW+1)'(MEM_BASE);

  logic         req_s;
  logic         req_seen;
  logic         ack_r;
  logic         pending;
  logic         push;
  logic         pop;
  logic         load;
  logic [1:0]   count;
  fifo_entry_t  din;
  fifo_entry_t  head;
  drain_state_t state, state_nxt;

  // Request detect
`ifdef ROM_REQ_SYNC_EN
  logic [1:0] req_sync;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      req_sync <= '0;
      req_s    <= 1'b0;
    end else begin
      req_sync <= {req_sync[0], rom.rom_wr_req};
      req_s    <= req_sync[1];
    end
  end
`else
  always_ff @(posedge clk_sys) begin
    if (RESET) req_s <= 1'b0;
    else       req_s <= rom.rom_wr_req;
  end
`endif

  assign pending = (req_s != req_seen);
  assign push    = pending && (count != 2'd2);

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      req_seen <= 1'b0;
      ack_r    <= 1'b0;
    end else if (push) begin
      req_seen <= req_s;
      ack_r    <= ~ack_r;
    end
  end

  assign rom.rom_wr_ack = ack_r;

  // Capture FIFO
  always_comb begin
    din      = '0;
    din.addr = rom.rom_addr;
    din.data = rom.rom_data;
  end

  rom_wr_fifo2 u_fifo (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  // Drain FSM: the head stays in the FIFO (and counts toward full) until
  // its write is committed, so the FIFO bounds words in flight to two.
  always_ff @(posedge clk_sys) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          load      = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      mem_addr  <= {1'b0, head.addr} + BASE;
      mem_wdata <= head.data;
    end
  end

  // Leaving WRITE always passes through IDLE, giving the one-cycle gap.
  assign mem_req = (state == WRITE);
  assign mem_be  = 2'b11;
  assign busy    = (count != 2'd0) || mem_req;

  // Download tracking and mirror mask
  logic          dl_q;
  logic          dl_rise;
  logic          dl_fall;
  logic          mask_pend;
  logic [AW-1:0] max_addr;
  logic [AW-1:0] max_base;

  assign dl_rise = downloading && !dl_q;
  assign dl_fall = !downloading && dl_q;

  // A capture coinciding with a download start counts toward the new download.
  always_comb begin
    max_base = dl_rise ? '0 : max_addr;
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      dl_q       <= 1'b0;
      max_addr   <= '0;
      rom_mask   <= '0;
      mask_valid <= 1'b0;
      mask_pend  <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (push && (rom.rom_addr > max_base)) max_addr <= rom.rom_addr;
      else                                   max_addr <= max_base;
      if (dl_rise) begin
        mask_valid <= 1'b0;
        mask_pend  <= 1'b0;
      end else if (dl_fall) begin
        mask_pend <= 1'b1;
      end else if (mask_pend && !busy) begin
        rom_mask   <= mask_of(max_addr);
        mask_valid <= 1'b1;
        mask_pend  <= 1'b0;
      end
    end
  end

endmodule
